// File: rtl/command_issuer.sv
// command_issuer: buffers commands from a producer in a circular FIFO and
// issues them one at a time to the ALU controller with a one-cycle syscall
// strobe, then waits for ctrl_ready before issuing the next. The ALU flags
// are captured at every completion.
//
// Optional feature macro: CMD_ISSUER_STATS_EN adds the issued_cnt and
// cas_hit_cnt statistics outputs.
//
// Handshakes: the producer side is valid/ready. A push happens on a rising
// edge where cmd_valid && cmd_ready. cmd_ready is derived from the
// registered occupancy only. The controller side is strobe/ready: syscall
// pulses once per command, and ctrl_ready is sampled only while waiting
// for completion.
module command_issuer #(
    parameter int DEPTH = 8,
    parameter int CMD_W = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CMD_W-1:0]         cmd_in,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    output logic [CMD_W-1:0]         command,
    output logic                     syscall,
    input  logic                     ctrl_ready,
    input  logic                     O,
    input  logic                     C,
    input  logic                     Z,
    input  logic                     N,
    output logic [3:0]               flags_q,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count,
`ifdef CMD_ISSUER_STATS_EN
    output logic [31:0]              issued_cnt,
    output logic [31:0]              cas_hit_cnt,
`endif
    output logic [1:0]               o_dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CMD_W-1:0] r_command;
    logic             r_syscall;
    logic             r_done;
    logic             r_busy;
    logic [3:0]       r_flags;
`ifdef CMD_ISSUER_STATS_EN
    logic [31:0]      r_issued_cnt;
    logic [31:0]      r_cas_hit_cnt;
`endif

    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // A push while full is dropped even if a pop happens on the same edge.
    assign w_full = (r_count == CW'(DEPTH));
    assign w_push = cmd_valid && !w_full;
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

    assign cmd_ready   = !w_full;
    assign count       = r_count;
    assign command     = r_command;
    assign syscall     = r_syscall;
    assign done        = r_done;
    assign busy        = r_busy;
    assign flags_q     = r_flags;
    assign o_dbg_state = r_state;
`ifdef CMD_ISSUER_STATS_EN
    assign issued_cnt  = r_issued_cnt;
    assign cas_hit_cnt = r_cas_hit_cnt;
`endif

    // FIFO storage: written on every accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= cmd_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM: pop into the command register, strobe once, wait for completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_command     <= '0;
            r_syscall     <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
            r_flags       <= 4'b0000;
`ifdef CMD_ISSUER_STATS_EN
            r_issued_cnt  <= '0;
            r_cas_hit_cnt <= '0;
`endif
        end else begin
            r_syscall <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_command    <= r_mem[r_rd_ptr];
                        r_syscall    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
`ifdef CMD_ISSUER_STATS_EN
                        r_issued_cnt <= r_issued_cnt + 32'd1;
`endif
                    end
                end
                S_ISSUE: begin
                    // ctrl_ready is deliberately ignored here so a level left
                    // over from the previous command cannot complete this one.
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (ctrl_ready) begin
                        r_flags <= {O, C, Z, N};
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
`ifdef CMD_ISSUER_STATS_EN
                        if ((r_command[CMD_W-1 -: 3] == 3'b111) && Z) begin
                            r_cas_hit_cnt <= r_cas_hit_cnt + 32'd1;
                        end
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
